// File: rtl/spi_pkg.sv
// Shared defaults and types for the SPI transaction scheduler slice.
package spi_pkg;

    localparam int SPI_ADDR_WIDTH = 8;
    localparam int SPI_DATA_WIDTH = 8;

    typedef struct packed {
        logic                      wr;
        logic [SPI_ADDR_WIDTH-1:0] addr;
        logic [SPI_DATA_WIDTH-1:0] data;
    } spi_cmd_t;

    typedef enum logic {ARB, ISSUE} issue_state_t;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RSP} ret_state_t;

endpackage

// File: rtl/spi_tag_fifo.sv
// Small synchronous FIFO holding the requester ID of every outstanding read.
module spi_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                   SCLK,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge SCLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Round-robin command scheduler in front of the SPI write FIFO, with
// in-order routing of read data back to the requester that issued the read.
module spi_txn_scheduler
    import spi_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = SPI_ADDR_WIDTH,
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                                        SCLK,
    input  logic                                        reset,
    input  logic [NUM_REQ-1:0]                          req_valid,
    input  logic [NUM_REQ*(ADDR_WIDTH+DATA_WIDTH+1)-1:0] req_cmd,
    output logic [NUM_REQ-1:0]                          req_ready,
    input  logic                                        w_full,
    output logic                                        w_wr_en,
    output logic [ADDR_WIDTH+DATA_WIDTH:0]              w_din,
    input  logic                                        r_empty,
    output logic                                        r_rd_en,
    input  logic [DATA_WIDTH-1:0]                       r_dout,
    output logic [NUM_REQ-1:0]                          rsp_valid,
    output logic [DATA_WIDTH-1:0]                       rsp_data,
    output logic [$clog2(TAG_DEPTH):0]                  rd_pending,
    output logic                                        err_orphan
);

    localparam int CMD_W = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam int GW    = $clog2(NUM_REQ);

    issue_state_t     issue_state, issue_next;
    ret_state_t       ret_state, ret_next;
    logic [GW-1:0]    last_grant, grant_q, sel, cand;
    logic [NUM_REQ-1:0] eligible, req_ready_d;
    logic             any_elig, grant_load, w_wr_en_d;
    logic             r_rd_en_d, rsp_load, orphan_set;
    logic             tag_push, tag_pop, tag_full, tag_empty;
    logic [GW-1:0]    tag_dout;

    // A read is only eligible while a tag slot is free; writes never need one.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && !w_full && (req_cmd[i*CMD_W + CMD_W - 1] || !tag_full);
        end
    end

    always_comb begin
        any_elig = 1'b0;
        sel      = last_grant;
        cand     = last_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!any_elig && eligible[cand]) begin
                any_elig = 1'b1;
                sel      = cand;
            end
        end
    end

    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            issue_state <= ARB;
            last_grant  <= GW'(NUM_REQ - 1);
            grant_q     <= '0;
            w_wr_en     <= 1'b0;
            w_din       <= '0;
            req_ready   <= '0;
        end else begin
            issue_state <= issue_next;
            w_wr_en     <= w_wr_en_d;
            req_ready   <= req_ready_d;
            if (grant_load) begin
                grant_q <= sel;
                w_din   <= req_cmd[int'(sel)*CMD_W +: CMD_W];
            end
            if (issue_state == ISSUE) last_grant <= grant_q;
        end
    end

    always_comb begin
        issue_next = issue_state;
        case (issue_state)
            ARB:     if (any_elig) issue_next = ISSUE;
            ISSUE:   issue_next = ARB;
            default: issue_next = ARB;
        endcase
    end

    always_comb begin
        grant_load  = 1'b0;
        w_wr_en_d   = 1'b0;
        req_ready_d = '0;
        if (issue_state == ARB && any_elig) begin
            grant_load       = 1'b1;
            w_wr_en_d        = 1'b1;
            req_ready_d[sel] = 1'b1;
        end
    end

    assign tag_push = (issue_state == ISSUE) && !w_din[CMD_W-1];

    spi_tag_fifo #(
        .WIDTH (GW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .SCLK  (SCLK),
        .reset (reset),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (grant_q),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty),
        .count (rd_pending)
    );

    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            ret_state  <= R_IDLE;
            r_rd_en    <= 1'b0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            ret_state <= ret_next;
            r_rd_en   <= r_rd_en_d;
            rsp_valid <= '0;
            if (rsp_load) begin
                rsp_valid[tag_dout] <= 1'b1;
                rsp_data            <= r_dout;
            end
            if (orphan_set) err_orphan <= 1'b1;
        end
    end

    always_comb begin
        ret_next = ret_state;
        case (ret_state)
            R_IDLE:  if (!r_empty) ret_next = R_WAIT;
            R_WAIT:  ret_next = R_RSP;
            R_RSP:   ret_next = R_IDLE;
            default: ret_next = R_IDLE;
        endcase
    end

    // Data arriving with no outstanding tag is dropped and flagged.
    always_comb begin
        r_rd_en_d  = 1'b0;
        rsp_load   = 1'b0;
        tag_pop    = 1'b0;
        orphan_set = 1'b0;
        case (ret_state)
            R_IDLE: r_rd_en_d = !r_empty;
            R_RSP: begin
                if (!tag_empty) begin
                    rsp_load = 1'b1;
                    tag_pop  = 1'b1;
                end else begin
                    orphan_set = 1'b1;
                end
            end
            default: r_rd_en_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Scoreboard bench for spi_txn_scheduler: directed requester traffic and a
// read-FIFO model, with a decoupled monitor checking writes and responses.
module tb_spi_txn_scheduler;
    import spi_pkg::*;

    logic        SCLK;
    logic        reset;
    logic [1:0]  req_valid = '0;
    logic [33:0] req_cmd = '0;
    logic [1:0]  req_ready;
    logic        w_full = 1'b0;
    logic        w_wr_en;
    logic [16:0] w_din;
    logic        r_empty = 1'b1;
    logic        r_rd_en;
    logic [7:0]  r_dout = '0;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [2:0]  rd_pending;
    logic        err_orphan;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    int          exp_w_id[$];
    logic [16:0] exp_w_cmd[$];
    int          exp_r_id[$];
    logic [7:0]  exp_r_data[$];
    logic [7:0]  rdata_q[$];
    int          wr_stamp[$];
    int          rden_stamp[$];
    int          rsp_stamp[$];

    spi_txn_scheduler #(
        .NUM_REQ    (2),
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .TAG_DEPTH  (4)
    ) dut (
        .SCLK       (SCLK),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_cmd    (req_cmd),
        .req_ready  (req_ready),
        .w_full     (w_full),
        .w_wr_en    (w_wr_en),
        .w_din      (w_din),
        .r_empty    (r_empty),
        .r_rd_en    (r_rd_en),
        .r_dout     (r_dout),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rd_pending (rd_pending),
        .err_orphan (err_orphan)
    );

    initial begin
        SCLK = 1'b0;
        forever #5 SCLK = ~SCLK;
    end

    initial forever begin
        @(posedge SCLK);
        cyc++;
    end

    function automatic logic [16:0] mk(input logic wr, input logic [7:0] a, input logic [7:0] d);
        spi_cmd_t c;
        c.wr   = wr;
        c.addr = a;
        c.data = d;
        return c;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue a command at a requester and record the write it must produce.
    task automatic apply_stimulus(input int id, input logic [16:0] cmd);
        if (id == 0) q0.push_back(cmd);
        else         q1.push_back(cmd);
        exp_w_id.push_back(id);
        exp_w_cmd.push_back(cmd);
    endtask

    task automatic expect_rsp(input int id, input logic [7:0] d);
        rdata_q.push_back(d);
        exp_r_id.push_back(id);
        exp_r_data.push_back(d);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge SCLK);
        #1;
    endtask

    task automatic wait_w(input int n);
        int t = 0;
        while (exp_w_cmd.size() > n && t < 300) begin
            @(negedge SCLK);
            t++;
        end
        if (exp_w_cmd.size() > n) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_write_timeout: got %0d pending writes, expected <= %0d", exp_w_cmd.size(), n);
        end
        #1;
    endtask

    task automatic wait_r();
        int t = 0;
        while (exp_r_id.size() > 0 && t < 300) begin
            @(negedge SCLK);
            t++;
        end
        if (exp_r_id.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_rsp_timeout: got %0d pending responses, expected 0", exp_r_id.size());
        end
        #1;
    endtask

    // Requester model: retire the head command on req_ready, present the next.
    initial forever begin
        @(negedge SCLK);
        if (req_ready[0] && q0.size() > 0) q0.delete(0);
        if (req_ready[1] && q1.size() > 0) q1.delete(0);
        req_valid[0]   = (q0.size() > 0);
        req_valid[1]   = (q1.size() > 0);
        req_cmd[16:0]  = (q0.size() > 0) ? q0[0] : '0;
        req_cmd[33:17] = (q1.size() > 0) ? q1[0] : '0;
    end

    // Read FIFO model: r_dout becomes valid the cycle after r_rd_en.
    initial forever begin
        @(negedge SCLK);
        if (r_rd_en) begin
            rden_stamp.push_back(cyc);
            if (rdata_q.size() > 0) r_dout = rdata_q.pop_front();
        end
        r_empty = (rdata_q.size() == 0);
    end

    initial begin : monitor
        int          id;
        logic [16:0] c;
        logic [7:0]  d;
        forever begin
            @(negedge SCLK);
            if (w_wr_en) begin
                wr_stamp.push_back(cyc);
                if (exp_w_cmd.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: got w_din=%h, expected no write", w_din);
                end else begin
                    id = exp_w_id.pop_front();
                    c  = exp_w_cmd.pop_front();
                    check_output("w_din", 32'(w_din), 32'(c));
                    check_output("req_ready", 32'(req_ready), 32'(1) << id);
                end
            end else if (req_ready != 2'b00) begin
                total++;
                bad++;
                $display("[TB] FAIL stray_ready: got req_ready=%b without w_wr_en, expected 00", req_ready);
            end
            if (rsp_valid != 2'b00) begin
                rsp_stamp.push_back(cyc);
                if (exp_r_id.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=%b data=%h, expected none", rsp_valid, rsp_data);
                end else begin
                    id = exp_r_id.pop_front();
                    d  = exp_r_data.pop_front();
                    check_output("rsp_valid", 32'(rsp_valid), 32'(1) << id);
                    check_output("rsp_data", 32'(rsp_data), 32'(d));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no finish by 300000, expected earlier finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int act;
        int t0;

        // Reset values, then a reset landing in the middle of an ISSUE cycle.
        reset = 1'b1;
        tick(3);
        check_output("rst_ctrl", {27'b0, w_wr_en, req_ready, r_rd_en, rsp_valid, err_orphan}, 32'h0);
        check_output("rst_w_din", 32'(w_din), 32'h0);
        check_output("rst_rsp_data", 32'(rsp_data), 32'h0);
        check_output("rst_rd_pending", 32'(rd_pending), 32'h0);
        reset = 1'b0;
        tick(1);
        apply_stimulus(1, mk(1'b0, 8'h0F, 8'h00));
        wait_w(0);
        tick(2);
        check_output("pend_before_rst", 32'(rd_pending), 32'd1);
        apply_stimulus(0, mk(1'b1, 8'h01, 8'h11));
        apply_stimulus(0, mk(1'b1, 8'h01, 8'h12));
        apply_stimulus(1, mk(1'b1, 8'h02, 8'h22));
        t = 0;
        do begin
            @(negedge SCLK);
            t++;
        end while (!w_wr_en && t < 50);
        #1 reset = 1'b1;
        #1;
        check_output("midrst_w_wr_en", 32'(w_wr_en), 32'h0);
        check_output("midrst_req_ready", 32'(req_ready), 32'h0);
        check_output("midrst_rd_pending", 32'(rd_pending), 32'h0);
        tick(2);
        reset = 1'b0;
        wait_w(0);

        // Round robin across two requesters each holding three writes.
        tick(2);
        wr_stamp.delete();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, mk(1'b1, 8'h12, 8'(8'h34 + i)));
            apply_stimulus(1, mk(1'b1, 8'h22, 8'(8'h34 + i)));
        end
        wait_w(0);
        tick(2);
        check_output("rr_write_count", 32'(wr_stamp.size()), 32'd6);
        for (int i = 1; i < 6 && i < wr_stamp.size(); i++) begin
            check_output("rr_write_spacing", 32'(wr_stamp[i] - wr_stamp[i-1]), 32'd2);
        end

        // Read routing: req1 reads first, req0 second, data returns in order.
        apply_stimulus(1, mk(1'b0, 8'h05, 8'h00));
        wait_w(0);
        apply_stimulus(0, mk(1'b0, 8'h07, 8'h00));
        wait_w(0);
        tick(2);
        check_output("route_pending", 32'(rd_pending), 32'd2);
        rden_stamp.delete();
        rsp_stamp.delete();
        expect_rsp(1, 8'hAA);
        expect_rsp(0, 8'h55);
        wait_r();
        tick(2);
        check_output("route_rden_count", 32'(rden_stamp.size()), 32'd2);
        check_output("route_rsp_count", 32'(rsp_stamp.size()), 32'd2);
        if (rden_stamp.size() == 2 && rsp_stamp.size() == 2) begin
            check_output("route_latency0", 32'(rsp_stamp[0] - rden_stamp[0]), 32'd2);
            check_output("route_latency1", 32'(rsp_stamp[1] - rden_stamp[1]), 32'd2);
        end
        check_output("route_pending_done", 32'(rd_pending), 32'd0);

        // Tag FIFO full: a fifth read waits while a write from req1 passes it.
        for (int i = 0; i < 4; i++) apply_stimulus(0, mk(1'b0, 8'(8'h40 + i), 8'h00));
        wait_w(0);
        tick(2);
        check_output("full_pending", 32'(rd_pending), 32'd4);
        apply_stimulus(1, mk(1'b1, 8'h50, 8'h66));
        apply_stimulus(0, mk(1'b0, 8'h44, 8'h00));
        wait_w(1);
        tick(8);
        check_output("full_read_held", 32'(exp_w_cmd.size()), 32'd1);
        check_output("full_pending_hold", 32'(rd_pending), 32'd4);
        expect_rsp(0, 8'h01);
        wait_w(0);
        for (int i = 2; i <= 5; i++) expect_rsp(0, 8'(i));
        wait_r();
        tick(2);
        check_output("full_pending_done", 32'(rd_pending), 32'd0);

        // Back-pressure: nothing leaves while w_full is high.
        w_full = 1'b1;
        apply_stimulus(1, mk(1'b1, 8'h61, 8'h02));
        apply_stimulus(0, mk(1'b1, 8'h60, 8'h01));
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge SCLK);
            if (w_wr_en || req_ready != 2'b00) act++;
        end
        check_output("bp_no_activity", 32'(act), 32'd0);
        check_output("bp_writes_held", 32'(exp_w_cmd.size()), 32'd2);
        wr_stamp.delete();
        @(posedge SCLK);
        #1 w_full = 1'b0;
        t0 = cyc;
        wait_w(0);
        // The cycle w_full drops is the ARB cycle; the ISSUE pulse is the next one.
        if (wr_stamp.size() > 0) check_output("bp_first_grant_latency", 32'(wr_stamp[0] - t0), 32'd1);
        else check_output("bp_first_grant_seen", 32'(wr_stamp.size()), 32'd1);

        // Orphan data, then a tag push and pop landing on the same edge.
        tick(2);
        check_output("orphan_clear", 32'(err_orphan), 32'd0);
        rdata_q.push_back(8'hEE);
        tick(8);
        check_output("orphan_set", 32'(err_orphan), 32'd1);
        check_output("orphan_pending", 32'(rd_pending), 32'd0);
        apply_stimulus(0, mk(1'b0, 8'h70, 8'h00));
        wait_w(0);
        tick(2);
        check_output("simul_pending_pre", 32'(rd_pending), 32'd1);
        expect_rsp(0, 8'hC3);
        tick(1);
        apply_stimulus(1, mk(1'b0, 8'h71, 8'h00));
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check_output("simul_pending", 32'(rd_pending), 32'd1);
        end
        expect_rsp(1, 8'h3C);
        wait_r();
        tick(2);
        check_output("final_pending", 32'(rd_pending), 32'd0);
        check_output("orphan_sticky", 32'(err_orphan), 32'd1);
        check_output("final_w_queue", 32'(exp_w_cmd.size()), 32'd0);
        check_output("final_r_queue", 32'(exp_r_id.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
